// File: rtl/overdrive_pkg.sv
// overdrive_pkg: shared gain type, unity helper and control-state enum for the overdrive gain controller.
package overdrive_pkg;

    typedef logic signed [15:0] gain_t;

    typedef enum logic [1:0] {DRY, RAMP_UP, WET, RAMP_DOWN} od_ctrl_state_t;

    function automatic gain_t UNITY_GAIN(input int bits);
        return gain_t'(1 << bits);
    endfunction

endpackage

// File: rtl/overdrive_gain_step.sv
// overdrive_gain_step: one slew step of the gain toward its goal.
// OVERDRIVE_GAIN_CTRL_RAMP_EN selects the geometric slew; without it the goal is reached in one step.
module overdrive_gain_step
    import overdrive_pkg::*;
#(
    parameter int RAMP_SHIFT = 6
) (
    input  gain_t cur,
    input  gain_t goal,
    output gain_t next,
    output logic  at_goal
);
`ifdef OVERDRIVE_GAIN_CTRL_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    logic signed [16:0] diff, shr, slew, step, sum;
    always_comb begin
        diff    = {goal[15], goal} - {cur[15], cur};
        shr     = diff >>> RAMP_SHIFT;
        // Small differences still creep by one LSB so the goal is always reached.
        slew    = (shr == 17'sd0 && diff != 17'sd0) ? (diff[16] ? -17'sd1 : 17'sd1) : shr;
        step    = RAMP_EN ? slew : diff;
        sum     = {cur[15], cur} + step;
        next    = sum[15:0];
        at_goal = diff == 17'sd0;
    end

endmodule

// File: rtl/overdrive_gain_ctrl.sv
// overdrive_gain_ctrl: accepts gain targets, slews gain per sample tick and sequences the dry/overdrive switch at unity.
// OVERDRIVE_GAIN_CTRL_RAMP_EN enables slewed steps; otherwise each ramp completes on a single tick.
module overdrive_gain_ctrl
    import overdrive_pkg::*;
#(
    parameter int                 BITS_PER_LEVEL = 12,
    parameter int                 RAMP_SHIFT     = 6,
    parameter logic signed [15:0] GAIN_MAX       = 16'sh7FFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic signed [15:0] target_gain,
    input  logic               target_valid,
    output logic               target_ready,
    input  logic               bypass_req,
    output logic signed [15:0] gain_out,
    output logic               dry_sel,
    output logic               ramping
);
    localparam gain_t UNITY = UNITY_GAIN(BITS_PER_LEVEL);

    od_ctrl_state_t state_q, state_d;
    gain_t          gain_q, gain_d, tgt_q, tgt_d, goal, step_next, tgt_in;
    logic           dry_q, dry_d, ramping_q, ramping_d, at_goal;

    function automatic gain_t goal_of(input od_ctrl_state_t s, input gain_t t);
        return (s == RAMP_UP || s == WET) ? t : UNITY;
    endfunction

    overdrive_gain_step #(.RAMP_SHIFT(RAMP_SHIFT)) u_step (
        .cur     (gain_q),
        .goal    (goal),
        .next    (step_next),
        .at_goal (at_goal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DRY;
            gain_q    <= UNITY;
            tgt_q     <= UNITY;
            dry_q     <= 1'b1;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            tgt_q     <= tgt_d;
            dry_q     <= dry_d;
            ramping_q <= ramping_d;
        end
    end

    // Bypass requests take priority over reaching the ramp-up goal.
    always_comb begin
        unique case (state_q)
            DRY:     state_d = bypass_req ? DRY : RAMP_UP;
            RAMP_UP: state_d = bypass_req ? RAMP_DOWN : (gain_q == tgt_q ? WET : RAMP_UP);
            WET:     state_d = bypass_req ? RAMP_DOWN : WET;
            default: state_d = gain_q == UNITY ? DRY : RAMP_DOWN;
        endcase
    end

    always_comb begin
        target_ready = state_q != RAMP_DOWN;
        tgt_in       = target_gain < 0 ? '0 : (target_gain > GAIN_MAX ? GAIN_MAX : target_gain);
        tgt_d        = (target_valid && target_ready) ? tgt_in : tgt_q;
        goal         = goal_of(state_q, tgt_q);
        gain_d       = (sample_tick && !at_goal) ? step_next : gain_q;
        dry_d        = state_d == DRY;
        ramping_d    = gain_d != goal_of(state_d, tgt_d);
    end

    assign gain_out = gain_q;
    assign dry_sel  = dry_q;
    assign ramping  = ramping_q;

endmodule

// File: tb/tb_overdrive_gain_ctrl.sv
// tb_overdrive_gain_ctrl: scoreboard bench; a behavioural model queues expected outputs per cycle, a monitor checks them.
module tb_overdrive_gain_ctrl;

    localparam int UNITY = 4096;
    localparam int DIV   = 64;
    localparam int GMAX  = 32767;

    logic               clk = 1'b0;
    logic               rst, sample_tick, target_valid, bypass_req;
    logic signed [15:0] target_gain;
    logic               target_ready, dry_sel, ramping;
    logic signed [15:0] gain_out;

    always #5 clk = ~clk;

    overdrive_gain_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .target_gain  (target_gain),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .bypass_req   (bypass_req),
        .gain_out     (gain_out),
        .dry_sel      (dry_sel),
        .ramping      (ramping)
    );

    typedef struct {
        int gain;
        bit dry;
        bit rdy;
        bit ramp;
    } exp_t;

    typedef enum {M_BYPASSED, M_ENGAGING, M_ENGAGED, M_RELEASING} mode_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    checks = 0;
    int    fails  = 0;
    mode_t m_mode;
    int    m_gain, m_tgt;

    function automatic int goal_for(input mode_t md, input int t);
        return (md == M_ENGAGING || md == M_ENGAGED) ? t : UNITY;
    endfunction

    // Step = diff/64 rounded toward minus infinity, at least one LSB toward the goal.
    function automatic int approach(input int cur, input int goal);
        int d, s;
        d = goal - cur;
`ifdef OVERDRIVE_GAIN_CTRL_RAMP_EN
        s = (d >= 0) ? d / DIV : -((-d + DIV - 1) / DIV);
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
`else
        s = d;
`endif
        return cur + s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit v, input int g, input bit b);
        exp_t  e;
        mode_t nm;
        int    ng, nt;
        rst          = r;
        sample_tick  = t;
        target_valid = v;
        target_gain  = g[15:0];
        bypass_req   = b;
        if (r) begin
            m_mode = M_BYPASSED;
            m_gain = UNITY;
            m_tgt  = UNITY;
        end else begin
            ng = t ? approach(m_gain, goal_for(m_mode, m_tgt)) : m_gain;
            nt = (v && m_mode != M_RELEASING) ? (g < 0 ? 0 : (g > GMAX ? GMAX : g)) : m_tgt;
            nm = m_mode;
            if (m_mode == M_BYPASSED && !b) nm = M_ENGAGING;
            else if ((m_mode == M_ENGAGING || m_mode == M_ENGAGED) && b) nm = M_RELEASING;
            else if (m_mode == M_ENGAGING && m_gain == m_tgt) nm = M_ENGAGED;
            else if (m_mode == M_RELEASING && m_gain == UNITY) nm = M_BYPASSED;
            m_mode = nm;
            m_gain = ng;
            m_tgt  = nt;
        end
        e.gain = m_gain;
        e.dry  = m_mode == M_BYPASSED;
        e.rdy  = m_mode != M_RELEASING;
        e.ramp = m_gain != goal_for(m_mode, m_tgt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("gain_out", int'(gain_out), mon_e.gain);
                chk("dry_sel", int'(dry_sel), int'(mon_e.dry));
                chk("target_ready", int'(target_ready), int'(mon_e.rdy));
                chk("ramping", int'(ramping), int'(mon_e.ramp));
            end
        end
    end

    initial begin
        bit byp;
        int g;
        repeat (3) cyc(1, 0, 0, 0, 1);
        repeat (4) cyc(0, 1, 0, 0, 1);
        // Engage toward 8192 after storing the target while dry.
        cyc(0, 0, 1, 8192, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (400) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        // Back to unity, then the fine +1 tail up to 4100.
        cyc(0, 0, 1, 4096, 0);
        repeat (400) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 4100, 0);
        repeat (6) cyc(0, 1, 0, 0, 0);
        // Negative target clamps to zero; then an accept colliding with a tick.
        cyc(0, 0, 1, -5, 0);
        repeat (20) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 6000, 0);
        repeat (50) cyc(0, 1, 0, 0, 0);
        // Bypass sequence with a refused target and an early release of the request.
        cyc(0, 0, 1, 8192, 0);
        repeat (500) cyc(0, 1, 0, 0, 0);
        repeat (20) cyc(0, 1, 1, 1234, 1);
        repeat (400) cyc(0, 1, 0, 0, 0);
        // Mid-ramp reset.
        cyc(0, 0, 1, 20000, 0);
        repeat (30) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        byp = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) byp = ~byp;
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                             : int'($urandom_range(0, 12000));
            cyc($urandom_range(0, 1499) == 0, $urandom_range(0, 1) == 0,
                $urandom_range(0, 29) == 0, g, byp);
        end
        cyc(0, 0, 0, 0, byp);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
